// File: rtl/edit_mem_rd_arb_pkg.sv
// Shared definitions for the edit memory read arbiter: width defaults,
// FSM encoding and the tag entry that follows each read back to its owner.
package edit_mem_rd_arb_pkg;

  localparam int ENQ_ED_CMD_PD_BP_NBITS = 8;
  localparam int PD_CHUNK_DEPTH_NBITS   = 4;
  localparam int DATA_PATH_VB_NBITS     = 2;
  localparam int DATA_PATH_NBITS        = 32;
  localparam int PORT_ID_NBITS          = 4;

  localparam int DEF_MAX_OUT = 8;
  localparam int TAG_NBITS   = PORT_ID_NBITS + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic [PORT_ID_NBITS-1:0] port_id;
    logic                     eop;
  } tag_t;

endpackage

// File: rtl/edit_mem_rr_arb.sv
// Round-robin grant: search begins one past the last granted port and wraps.
module edit_mem_rr_arb #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_NBITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_NBITS-1:0] last_ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PTR_NBITS-1:0] next_ptr
);

  int idx;

  // Walk from farthest to nearest candidate so the nearest requester wins.
  always_comb begin
    grant    = '0;
    next_ptr = last_ptr;
    idx      = 0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(last_ptr) + k) % NUM_PORTS;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        next_ptr   = PTR_NBITS'(idx);
      end
    end
  end

endmodule

// File: rtl/edit_mem_rd_arb.sv
// Arbitrates burst read requests onto the edit memory, limits outstanding
// reads and routes in-order read data back to the owning requester.
module edit_mem_rd_arb
  import edit_mem_rd_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_NBITS = ENQ_ED_CMD_PD_BP_NBITS + PD_CHUNK_DEPTH_NBITS - DATA_PATH_VB_NBITS,
  parameter int DATA_NBITS = DATA_PATH_NBITS,
  parameter int LEN_NBITS  = PD_CHUNK_DEPTH_NBITS,
  parameter int MAX_OUT    = DEF_MAX_OUT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            rq_valid,
  input  logic [NUM_PORTS*ADDR_NBITS-1:0] rq_addr,
  input  logic [NUM_PORTS*LEN_NBITS-1:0]  rq_len,
  output logic [NUM_PORTS-1:0]            rq_ack,
  output logic                            edit_mem_req,
  output logic [ADDR_NBITS-1:0]           edit_mem_raddr,
  output logic [PORT_ID_NBITS-1:0]        edit_mem_port_id,
  output logic                            edit_mem_eop,
  input  logic                            edit_mem_ack,
  input  logic [DATA_NBITS-1:0]           edit_mem_rdata,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DATA_NBITS-1:0]           rsp_data,
  output logic                            rsp_eop,
  output logic                            err_underflow
);

  // state    | meaning
  // ST_IDLE  | no burst active; grant the next requester round-robin
  // ST_BURST | issuing words of the latched burst, stalls at MAX_OUT outstanding

  localparam int PTR_NBITS  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int FIFO_NBITS = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_NBITS  = FIFO_NBITS + 1;
  localparam logic [CNT_NBITS-1:0] MAX_CNT = CNT_NBITS'(MAX_OUT);
  localparam logic [LEN_NBITS-1:0] LEN_ONE = LEN_NBITS'(1);

  rd_state_e                state;
  logic [PTR_NBITS-1:0]     rr_ptr;
  logic [NUM_PORTS-1:0]     arb_grant;
  logic [PTR_NBITS-1:0]     arb_next;
  logic [ADDR_NBITS-1:0]    sel_addr;
  logic [LEN_NBITS-1:0]     sel_len;
  logic [ADDR_NBITS-1:0]    cur_addr;
  logic [LEN_NBITS-1:0]     remain;
  logic [PORT_ID_NBITS-1:0] cur_id;
  logic [CNT_NBITS-1:0]     outstanding;
  logic [FIFO_NBITS-1:0]    wr_ptr;
  logic [FIFO_NBITS-1:0]    rd_ptr;
  logic [TAG_NBITS-1:0]     tag_mem [MAX_OUT];
  tag_t                     rd_tag;
  logic                     issue;
  logic                     pop;

  edit_mem_rr_arb #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_NBITS (PTR_NBITS)
  ) u_rr_arb (
    .req      (rq_valid),
    .last_ptr (rr_ptr),
    .grant    (arb_grant),
    .next_ptr (arb_next)
  );

  assign sel_addr = rq_addr[int'(arb_next)*ADDR_NBITS +: ADDR_NBITS];
  assign sel_len  = rq_len[int'(arb_next)*LEN_NBITS +: LEN_NBITS];
  assign issue    = (state == ST_BURST) && (outstanding < MAX_CNT);
  assign pop      = edit_mem_ack && (outstanding != '0);
  assign rd_tag   = tag_t'(tag_mem[rd_ptr]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      rr_ptr           <= PTR_NBITS'(NUM_PORTS - 1);
      cur_addr         <= '0;
      remain           <= '0;
      cur_id           <= '0;
      rq_ack           <= '0;
      edit_mem_req     <= 1'b0;
      edit_mem_raddr   <= '0;
      edit_mem_port_id <= '0;
      edit_mem_eop     <= 1'b0;
    end else begin
      rq_ack           <= '0;
      edit_mem_req     <= 1'b0;
      edit_mem_raddr   <= '0;
      edit_mem_port_id <= '0;
      edit_mem_eop     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|rq_valid) begin
            rq_ack   <= arb_grant;
            rr_ptr   <= arb_next;
            cur_addr <= sel_addr;
            remain   <= (sel_len == '0) ? LEN_ONE : sel_len;
            cur_id   <= PORT_ID_NBITS'(arb_next);
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (issue) begin
            edit_mem_req     <= 1'b1;
            edit_mem_raddr   <= cur_addr;
            edit_mem_port_id <= cur_id;
            edit_mem_eop     <= (remain == LEN_ONE);
            cur_addr         <= cur_addr + ADDR_NBITS'(1);
            remain           <= remain - LEN_ONE;
            if (remain == LEN_ONE) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The tag FIFO occupancy always equals the outstanding count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding   <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      rsp_eop       <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (issue) wr_ptr <= wr_ptr + FIFO_NBITS'(1);
      if (pop)   rd_ptr <= rd_ptr + FIFO_NBITS'(1);
      if (issue && !pop)      outstanding <= outstanding + CNT_NBITS'(1);
      else if (!issue && pop) outstanding <= outstanding - CNT_NBITS'(1);
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_eop   <= 1'b0;
      if (pop) begin
        rsp_valid <= NUM_PORTS'(1) << rd_tag.port_id;
        rsp_data  <= edit_mem_rdata;
        rsp_eop   <= rd_tag.eop;
      end
      if (edit_mem_ack && (outstanding == '0)) err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr] <= {cur_id, (remain == LEN_ONE)};
  end

endmodule
